// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment code table for the segment readback path.
// Segment bit order: bit6=a ... bit0=g, 1 = lit.
package seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] hex_t;

  // Index i holds the segment pattern that encodes hex digit i.
  localparam seg_t SEG_CODE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  localparam seg_t SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } rd_state_e;

endpackage

// File: rtl/seg_pattern_encoder.sv
// Combinational segment-pattern to hex recovery by searching the code table.
// valid_o flags a code-table match; blank_o flags an all-dark digit, which is
// only recognised when SEG_SCAN_READER_BLANK_EN is defined.
module seg_pattern_encoder
  import seg_pkg::*;
(
  input  seg_t seg_i,
  output hex_t hex_o,
  output logic valid_o,
  output logic blank_o
);

  // Table search; blank reports nibble 0 so the frame slot reads as zero.
  always_comb begin
    hex_o   = '0;
    valid_o = 1'b0;
    blank_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_CODE[i]) begin
        hex_o   = hex_t'(i);
        valid_o = 1'b1;
      end
    end
`ifdef SEG_SCAN_READER_BLANK_EN
    if (seg_i == SEG_BLANK) begin
      blank_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Multiplexed 7-segment bus reader: debounces each one-hot digit, decodes it
// into a shadow frame and publishes complete frames over valid/ready.
// Optional: SEG_SCAN_READER_BLANK_EN accepts 7'h00 as a blank digit and adds blank_o.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   dig_sel_i,
  output logic [4*NUM_DIGITS-1:0] frame_o,
  output logic                    frame_valid_o,
  input  logic                    frame_ready_i,
  output logic                    pattern_err_o,
`ifdef SEG_SCAN_READER_BLANK_EN
  output logic [NUM_DIGITS-1:0]   blank_o,
`endif
  output logic                    overrun_o
);

  localparam int SW = NUM_DIGITS + 7;

  rd_state_e               state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [SW-1:0]           smp_q;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    ovr_q, ovr_d;
`ifdef SEG_SCAN_READER_BLANK_EN
  logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
`endif

  logic onehot, same, restart, capture, accept;
  hex_t pat_hex;
  logic pat_valid, pat_blank;

  assign onehot = $onehot(dig_sel_i);
  assign same   = ({dig_sel_i, seg_i} == smp_q);
  assign accept = pat_valid | pat_blank;

  seg_pattern_encoder u_enc (
    .seg_i   (seg_i),
    .hex_o   (pat_hex),
    .valid_o (pat_valid),
    .blank_o (pat_blank)
  );

  // Debounce FSM: counts identical cycles, fires capture once per stable pattern.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      SETTLE: begin
        if (!onehot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (same) begin
          if (({1'b0, cnt_q} + 9'd1) >= 9'(STABLE_CYCLES)) begin
            capture = 1'b1;
            state_d = CAPTURED;
            cnt_d   = 8'(STABLE_CYCLES);
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          restart = 1'b1;
        end
      end
      CAPTURED: begin
        if (!onehot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          restart = 1'b1;
        end
      end
      default: begin
        if (onehot) restart = 1'b1;
      end
    endcase
    // A new pattern is its own first stable cycle, so STABLE_CYCLES=1 captures at once.
    if (restart) begin
      cnt_d = 8'd1;
      if (STABLE_CYCLES == 1) begin
        capture = 1'b1;
        state_d = CAPTURED;
      end else begin
        state_d = SETTLE;
      end
    end
  end

  // Shadow frame, seen mask, frame publication and handshake.
  always_comb begin
    shadow_d = shadow_q;
    seen_d   = seen_q;
    frame_d  = frame_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    ovr_d    = 1'b0;
`ifdef SEG_SCAN_READER_BLANK_EN
    blank_sh_d = blank_sh_q;
    blank_d    = blank_q;
`endif
    if (valid_q && frame_ready_i) valid_d = 1'b0;
    if (capture) begin
      if (accept) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (dig_sel_i[k]) begin
            shadow_d[4*k +: 4] = pat_hex;
`ifdef SEG_SCAN_READER_BLANK_EN
            blank_sh_d[k] = pat_blank;
`endif
          end
        end
        seen_d = seen_q | dig_sel_i;
        if (&seen_d) begin
          // Completion beats a same-cycle transfer; only an unaccepted frame is an overrun.
          frame_d = shadow_d;
          valid_d = 1'b1;
          ovr_d   = valid_q & ~frame_ready_i;
          seen_d  = '0;
`ifdef SEG_SCAN_READER_BLANK_EN
          blank_d = blank_sh_d;
`endif
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      smp_q    <= '0;
      shadow_q <= '0;
      seen_q   <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef SEG_SCAN_READER_BLANK_EN
      blank_sh_q <= '0;
      blank_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      smp_q    <= {dig_sel_i, seg_i};
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
`ifdef SEG_SCAN_READER_BLANK_EN
      blank_sh_q <= blank_sh_d;
      blank_q    <= blank_d;
`endif
    end
  end

  assign frame_o       = frame_q;
  assign frame_valid_o = valid_q;
  assign pattern_err_o = err_q;
  assign overrun_o     = ovr_q;
`ifdef SEG_SCAN_READER_BLANK_EN
  assign blank_o = blank_q;
`endif

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: expected frames are queued as stimulus is
// issued and a negedge monitor pops/compares on every valid&ready transfer.
module tb_seg_scan_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        ready;
  logic [15:0] frame_o;
  logic        frame_valid_o;
  logic        pattern_err_o;
  logic        overrun_o;
`ifdef SEG_SCAN_READER_BLANK_EN
  logic [3:0]  blank_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int ovr_cnt  = 0;
  int vld_cyc  = 0;
  int e0, o0, v0;
  logic [15:0] exp_q[$];

  seg_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_i         (seg),
    .dig_sel_i     (dig_sel),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (ready),
    .pattern_err_o (pattern_err_o),
`ifdef SEG_SCAN_READER_BLANK_EN
    .blank_o       (blank_o),
`endif
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic [6:0] s, input int n);
    dig_sel = 4'(1 << d);
    seg     = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    drive(0, s0, 4);
    drive(1, s1, 4);
    drive(2, s2, 4);
    drive(3, s3, 4);
  endtask

  // Monitor: pulse counters and scoreboard compare on each transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pattern_err_o) err_cnt++;
      if (overrun_o) ovr_cnt++;
      if (frame_valid_o) vld_cyc++;
      if (frame_valid_o && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got %h expected none", frame_o);
        end else begin
          check("frame_xfer", 32'(frame_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dig_sel = '0;
    seg     = '0;
    ready   = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame", 32'(frame_o), 32'h0);
    check("rst_valid", 32'(frame_valid_o), 32'h0);
    check("rst_err", 32'(pattern_err_o), 32'h0);
    check("rst_ovr", 32'(overrun_o), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic scan and completion latency
    exp_q.push_back(16'h3210);
    drive(0, 7'h7E, 4);
    drive(1, 7'h30, 4);
    drive(2, 7'h6D, 4);
    drive(3, 7'h79, 2);
    check("basic_pre_valid", 32'(frame_valid_o), 32'h0);
    drive(3, 7'h79, 1);
    check("basic_valid", 32'(frame_valid_o), 32'h1);
    check("basic_frame", 32'(frame_o), 32'h3210);
    drive(3, 7'h79, 1);
    check("basic_valid_drop", 32'(frame_valid_o), 32'h0);
    check("basic_pulse_len", 32'(vld_cyc), 32'd1);

    // Glitch rejection on digit 1
    exp_q.push_back(16'h3270);
    drive(0, 7'h7E, 4);
    drive(1, 7'h7F, 2);
    drive(1, 7'h70, 3);
    drive(2, 7'h6D, 4);
    drive(3, 7'h79, 4);
    check("glitch_frame", 32'(frame_o), 32'h3270);

    // Invalid pattern on digit 2
    e0 = err_cnt;
    v0 = vld_cyc;
    drive(0, 7'h7E, 4);
    drive(1, 7'h30, 4);
    drive(3, 7'h79, 4);
    drive(2, 7'h01, 5);
    check("invalid_err_once", 32'(err_cnt - e0), 32'd1);
    check("invalid_no_frame", 32'(vld_cyc - v0), 32'd0);
    exp_q.push_back(16'h3210);
    drive(2, 7'h6D, 4);
    check("invalid_recover", 32'(frame_o), 32'h3210);
    check("invalid_err_total", 32'(err_cnt - e0), 32'd1);

`ifdef SEG_SCAN_READER_BLANK_EN
    e0 = err_cnt;
    exp_q.push_back(16'h3010);
    scan(7'h7E, 7'h30, 7'h00, 7'h79);
    check("blank_no_err", 32'(err_cnt - e0), 32'd0);
    check("blank_mask", 32'(blank_o), 32'h4);
    check("blank_frame", 32'(frame_o), 32'h3010);
`endif

    // Backpressure across two frames
    ready = 1'b0;
    o0 = ovr_cnt;
    v0 = vld_cyc;
    scan(7'h3D, 7'h4E, 7'h1F, 7'h77);
    check("bp_valid1", 32'(frame_valid_o), 32'h1);
    check("bp_frame1", 32'(frame_o), 32'hABCD);
    exp_q.push_back(16'h1F2E);
    drive(0, 7'h4F, 4);
    check("bp_hold", 32'(frame_o), 32'hABCD);
    drive(1, 7'h6D, 4);
    drive(2, 7'h47, 4);
    drive(3, 7'h30, 4);
    check("bp_frame2", 32'(frame_o), 32'h1F2E);
    check("bp_overrun", 32'(ovr_cnt - o0), 32'd1);
    check("bp_valid_cont", 32'(vld_cyc - v0), 32'd17);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("bp_valid_drop", 32'(frame_valid_o), 32'h0);

    // Transfer and completion on the same edge
    o0 = ovr_cnt;
    exp_q.push_back(16'h4567);
    exp_q.push_back(16'h89EF);
    scan(7'h70, 7'h5F, 7'h5B, 7'h33);
    drive(0, 7'h47, 4);
    drive(1, 7'h4F, 4);
    drive(2, 7'h7B, 4);
    drive(3, 7'h7F, 2);
    ready = 1'b1;
    drive(3, 7'h7F, 1);
    check("simul_valid", 32'(frame_valid_o), 32'h1);
    check("simul_frame", 32'(frame_o), 32'h89EF);
    drive(3, 7'h7F, 1);
    check("simul_valid_drop", 32'(frame_valid_o), 32'h0);
    check("simul_no_overrun", 32'(ovr_cnt - o0), 32'd0);

    // Multi-hot select is ignored
    v0 = vld_cyc;
    drive(0, 7'h7E, 4);
    drive(2, 7'h6D, 4);
    drive(3, 7'h79, 4);
    dig_sel = 4'b0110;
    seg     = 7'h30;
    repeat (10) @(posedge clk);
    #1;
    check("multihot_no_capture", 32'(vld_cyc - v0), 32'd0);
    exp_q.push_back(16'h3210);
    drive(1, 7'h30, 4);
    check("multihot_frame", 32'(frame_o), 32'h3210);

    // Reset mid-frame with a pending frame
    ready = 1'b0;
    scan(7'h7E, 7'h30, 7'h6D, 7'h79);
    drive(0, 7'h4F, 4);
    drive(1, 7'h47, 4);
    drive(2, 7'h33, 4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_frame", 32'(frame_o), 32'h0);
    check("mid_rst_valid", 32'(frame_valid_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    v0 = vld_cyc;
    drive(3, 7'h79, 4);
    check("post_rst_no_stale", 32'(vld_cyc - v0), 32'd0);
    exp_q.push_back(16'h3765);
    drive(0, 7'h5B, 4);
    drive(1, 7'h5F, 4);
    drive(2, 7'h70, 4);
    check("post_rst_frame", 32'(frame_o), 32'h3765);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
